// File: rtl/branch_cmp_unit.sv
// branch_cmp_unit: registered branch-condition unit for the decode stage.
// Evaluates one of eight branch conditions on WIDTH-bit operands, stalls on
// operands that are not ready, honours downstream hold and flush, and presents
// the decision one cycle after acceptance.
// Optional feature macro: BRANCH_CMP_STATS_EN enables the saturating
// accepted-branch and taken-branch counters. When it is undefined, both
// counter ports are tied to zero and no counter flops exist.
module branch_cmp_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             stall_in,
  input  logic             flush,
  output logic             stall_out,
  output logic             out_valid,
  output logic             taken,
  output logic             equal,
  output logic             bge,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLEZ = 3'b010;
  localparam logic [2:0] OP_BGTZ = 3'b011;
  localparam logic [2:0] OP_BLTZ = 3'b100;
  localparam logic [2:0] OP_BGEZ = 3'b101;
  localparam logic [2:0] OP_BLT  = 3'b110;
  localparam logic [2:0] OP_BLTU = 3'b111;

  logic ops_ready;
  logic accept;
  logic eq_c;
  logic neg_c;
  logic zero_c;
  logic lt_s_c;
  logic lt_u_c;
  logic cond_c;

  logic out_valid_q, out_valid_d;
  logic taken_q,     taken_d;
  logic equal_q,     equal_d;
  logic bge_q,       bge_d;

  assign ops_ready = a_ready & b_ready;
  assign stall_out = in_valid & ~ops_ready;
  assign accept    = in_valid & ops_ready & ~stall_in & ~flush;

  // Operand comparisons shared by the condition mux; signed compares use full WIDTH.
  always_comb begin
    eq_c   = (a == b);
    neg_c  = a[WIDTH-1];
    zero_c = (a == '0);
    lt_s_c = ($signed(a) < $signed(b));
    lt_u_c = (a < b);
  end

  // Branch condition selected by op.
  always_comb begin
    cond_c = 1'b0;
    unique case (op)
      OP_BEQ:  cond_c = eq_c;
      OP_BNE:  cond_c = ~eq_c;
      OP_BLEZ: cond_c = neg_c | zero_c;
      OP_BGTZ: cond_c = ~neg_c & ~zero_c;
      OP_BLTZ: cond_c = neg_c;
      OP_BGEZ: cond_c = ~neg_c;
      OP_BLT:  cond_c = lt_s_c;
      OP_BLTU: cond_c = lt_u_c;
      default: cond_c = 1'b0;
    endcase
  end

  // Next-state for the result register: flush, then hold, then accept, else bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    taken_d     = taken_q;
    equal_d     = equal_q;
    bge_d       = bge_q;
    if (flush) begin
      out_valid_d = 1'b0;
      taken_d     = 1'b0;
      equal_d     = 1'b0;
      bge_d       = 1'b0;
    end else if (stall_in) begin
      out_valid_d = out_valid_q;
    end else if (accept) begin
      out_valid_d = 1'b1;
      taken_d     = cond_c;
      equal_d     = eq_c;
      bge_d       = ~neg_c;
    end else begin
      out_valid_d = 1'b0;
      taken_d     = 1'b0;
    end
  end

  // Result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      equal_q     <= 1'b0;
      bge_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      taken_q     <= taken_d;
      equal_q     <= equal_d;
      bge_q       <= bge_d;
    end
  end

  assign out_valid = out_valid_q;
  assign taken     = taken_q;
  assign equal     = equal_q;
  assign bge       = bge_q;

`ifdef BRANCH_CMP_STATS_EN
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q,  taken_cnt_d;

  // Saturating counters; a flushed or held branch is never counted.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (accept && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (accept && cond_c && (taken_cnt_q != '1)) begin
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;
`else
  assign branch_cnt = '0;
  assign taken_cnt  = '0;
`endif

endmodule

// File: tb/tb_branch_cmp_unit.sv
// Directed self-checking bench for branch_cmp_unit (WIDTH=32, CNT_W=4).
module tb_branch_cmp_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CNT_MAX = 15;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLEZ = 3'b010;
  localparam logic [2:0] OP_BGTZ = 3'b011;
  localparam logic [2:0] OP_BLTZ = 3'b100;
  localparam logic [2:0] OP_BGEZ = 3'b101;
  localparam logic [2:0] OP_BLT  = 3'b110;
  localparam logic [2:0] OP_BLTU = 3'b111;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             a_ready;
  logic             b_ready;
  logic             stall_in;
  logic             flush;
  logic             stall_out;
  logic             out_valid;
  logic             taken;
  logic             equal;
  logic             bge;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  int n_cmp;
  int n_bad;
  int acc_m;
  int tkn_m;

  branch_cmp_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .op        (op),
    .a         (a),
    .b         (b),
    .a_ready   (a_ready),
    .b_ready   (b_ready),
    .stall_in  (stall_in),
    .flush     (flush),
    .stall_out (stall_out),
    .out_valid (out_valid),
    .taken     (taken),
    .equal     (equal),
    .bge       (bge),
    .branch_cnt(branch_cnt),
    .taken_cnt (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected counter value seen on the port for n modelled events.
  function automatic logic [31:0] cnt_exp(input int n);
`ifdef BRANCH_CMP_STATS_EN
    return (n > int'(CNT_MAX)) ? 32'(CNT_MAX) : 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  task automatic check_cnts(input string tag);
    check_eq({tag, ".branch_cnt"}, 32'(branch_cnt), cnt_exp(acc_m));
    check_eq({tag, ".taken_cnt"},  32'(taken_cnt),  cnt_exp(tkn_m));
  endtask

  task automatic check_out(input string tag, input logic ov, input logic tk,
                           input logic eq, input logic ge);
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check_eq({tag, ".taken"},     32'(taken),     32'(tk));
    check_eq({tag, ".equal"},     32'(equal),     32'(eq));
    check_eq({tag, ".bge"},       32'(bge),       32'(ge));
  endtask

  // Present one ready branch for a single edge; exp_tk updates the counter model.
  task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input logic exp_tk);
    op = o; a = va; b = vb;
    in_valid = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_m++;
    if (exp_tk) tkn_m++;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; acc_m = 0; tkn_m = 0;
    reset = 1'b1; in_valid = 1'b0; op = OP_BEQ; a = '0; b = '0;
    a_ready = 1'b0; b_ready = 1'b0; stall_in = 1'b0; flush = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_cnts("reset");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Equality pair.
    issue(OP_BEQ, 32'h0000_1234, 32'h0000_1234, 1'b1);
    check_out("beq", 1'b1, 1'b1, 1'b1, 1'b1);
    issue(OP_BNE, 32'h0000_1234, 32'h0000_1234, 1'b0);
    check_out("bne", 1'b1, 1'b0, 1'b1, 1'b1);

    // Signed vs unsigned with a = -1.
    issue(OP_BLT, 32'hFFFF_FFFF, 32'h1, 1'b1);
    check_out("blt_neg", 1'b1, 1'b1, 1'b0, 1'b0);
    issue(OP_BLTU, 32'hFFFF_FFFF, 32'h1, 1'b0);
    check_out("bltu_big", 1'b1, 1'b0, 1'b0, 1'b0);
    issue(OP_BLTZ, 32'hFFFF_FFFF, 32'h1, 1'b1);
    check_out("bltz", 1'b1, 1'b1, 1'b0, 1'b0);
    issue(OP_BLEZ, 32'h0, 32'h1, 1'b1);
    check_out("blez0", 1'b1, 1'b1, 1'b0, 1'b1);
    issue(OP_BGTZ, 32'h0, 32'h1, 1'b0);
    check_out("bgtz0", 1'b1, 1'b0, 1'b0, 1'b1);
    issue(OP_BGTZ, 32'h5, 32'h5, 1'b1);
    check_out("bgtz5", 1'b1, 1'b1, 1'b1, 1'b1);
    issue(OP_BGEZ, 32'h8000_0000, 32'h0, 1'b0);
    check_out("bgez_min", 1'b1, 1'b0, 1'b0, 1'b0);
    issue(OP_BLT, 32'h1, 32'hFFFF_FFFF, 1'b0);
    check_out("blt_pos", 1'b1, 1'b0, 1'b0, 1'b1);
    issue(OP_BLTU, 32'h1, 32'hFFFF_FFFF, 1'b1);
    check_out("bltu_small", 1'b1, 1'b1, 1'b0, 1'b1);

    // Bubble: valid and taken drop, equal/bge hold.
    @(posedge clk); #1;
    check_out("bubble", 1'b0, 1'b0, 1'b0, 1'b1);
    check_cnts("after_ops");

    // Operand-ready stall.
    op = OP_BEQ; a = 32'h7; b = 32'h7;
    in_valid = 1'b1; a_ready = 1'b1; b_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("rdy.stall_out", 32'(stall_out), 32'h1);
      check_eq("rdy.out_valid", 32'(out_valid), 32'h0);
    end
    b_ready = 1'b1;
    #1;
    check_eq("rdy.stall_out_clear", 32'(stall_out), 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_m++; tkn_m++;
    check_out("rdy.result", 1'b1, 1'b1, 1'b1, 1'b1);
    check_cnts("rdy");
    @(posedge clk); #1;
    check_eq("rdy.once", 32'(out_valid), 32'h0);

    // Hold under stall_in, with a competing branch that must not be accepted.
    issue(OP_BLTU, 32'h1, 32'h2, 1'b1);
    check_out("hold.pre", 1'b1, 1'b1, 1'b0, 1'b1);
    stall_in = 1'b1;
    op = OP_BNE; a = 32'h3; b = 32'h3; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_out("hold", 1'b1, 1'b1, 1'b0, 1'b1);
    end
    check_cnts("hold");
    flush = 1'b1;
    @(posedge clk); #1;
    check_out("flush_stall", 1'b0, 1'b0, 1'b0, 1'b0);
    check_cnts("flush_stall");

    // Flush together with an otherwise acceptable branch drops it.
    stall_in = 1'b0;
    op = OP_BEQ; a = 32'h9; b = 32'h9;
    @(posedge clk); #1;
    check_out("flush_acc", 1'b0, 1'b0, 1'b0, 1'b0);
    check_cnts("flush_acc");
    flush = 1'b0; in_valid = 1'b0;

    // Asynchronous reset between edges.
    issue(OP_BEQ, 32'h42, 32'h42, 1'b1);
    check_out("prereset", 1'b1, 1'b1, 1'b1, 1'b1);
    #2 reset = 1'b1;
    #1;
    acc_m = 0; tkn_m = 0;
    check_out("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_cnts("async_rst");
    @(negedge clk); reset = 1'b0;
    issue(OP_BNE, 32'h1, 32'h2, 1'b1);
    check_out("post_rst", 1'b1, 1'b1, 1'b0, 1'b1);

    // Back-to-back taken BEQs drive the counters into saturation.
    op = OP_BEQ; a = 32'hA5; b = 32'hA5;
    in_valid = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      acc_m++; tkn_m++;
      check_eq("b2b.out_valid", 32'(out_valid), 32'h1);
      check_eq("b2b.taken", 32'(taken), 32'h1);
    end
    in_valid = 1'b0;
    check_cnts("sat");
    @(posedge clk); #1;
    check_cnts("sat_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
